// File: rtl/pipe_mem_arbiter_if.sv
// Bundle for the unified memory arbiter: IF/MEM requester ports, the memory port and status.
// The arbiter takes the slave view; the pipeline/memory side takes the master view.
interface pipe_mem_arbiter_if #(
  parameter int DW = 32,
  parameter int AW = 10
) ();

  logic          halt;

  logic          d_req;
  logic          d_we;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic          d_ack;
  logic [DW-1:0] d_rdata;

  logic          i_req;
  logic [AW-1:0] i_addr;
  logic          i_ack;
  logic [DW-1:0] i_rdata;

  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  logic          busy;
  logic          gnt_data;

  modport slave (
    input  halt,
    input  d_req, d_we, d_addr, d_wdata,
    output d_ack, d_rdata,
    input  i_req, i_addr,
    output i_ack, i_rdata,
    output mem_en, mem_we, mem_addr, mem_wdata,
    input  mem_rdata,
    output busy, gnt_data
  );

  modport master (
    output halt,
    output d_req, d_we, d_addr, d_wdata,
    input  d_ack, d_rdata,
    output i_req, i_addr,
    input  i_ack, i_rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata,
    output mem_rdata,
    input  busy, gnt_data
  );

endinterface

// File: rtl/pipe_mem_arbiter.sv
// Single-port memory sequencer shared by instruction fetch and the MEM stage.
// Data has fixed priority; fetch is forced through after MAX_STARVE contested data wins.
module pipe_mem_arbiter #(
  parameter int DW         = 32,
  parameter int AW         = 10,
  parameter int RD_LAT     = 1,
  parameter int MAX_STARVE = 3
) (
  input  logic               clk,
  input  logic               reset,
  pipe_mem_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_DONE
  } state_t;

  state_t        r_state;
  logic [3:0]    r_starve_cnt;
  logic [2:0]    r_lat_cnt;

  logic          r_busy;
  logic          r_gnt_data;
  logic          r_d_ack;
  logic          r_i_ack;
  logic [DW-1:0] r_d_rdata;
  logic [DW-1:0] r_i_rdata;
  logic          r_mem_en;
  logic          r_mem_we;
  logic [AW-1:0] r_mem_addr;
  logic [DW-1:0] r_mem_wdata;

  logic          w_any_req;
  logic          w_contested;
  logic          w_fetch_forced;
  logic          w_pick_data;

  assign w_any_req      = bus.d_req | bus.i_req;
  assign w_contested    = bus.d_req & bus.i_req;
  assign w_fetch_forced = w_contested && (r_starve_cnt == 4'(MAX_STARVE));
  assign w_pick_data    = bus.d_req && !w_fetch_forced;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_starve_cnt <= '0;
      r_lat_cnt    <= '0;
      r_busy       <= 1'b0;
      r_gnt_data   <= 1'b0;
      r_d_ack      <= 1'b0;
      r_i_ack      <= 1'b0;
      r_d_rdata    <= '0;
      r_i_rdata    <= '0;
      r_mem_en     <= 1'b0;
      r_mem_we     <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_wdata  <= '0;
    end else begin
      // NOTE: non-blocking throughout, so every branch below sees pre-edge state;
      // the pulse outputs default low and are raised only in the cycle that needs them.
      r_d_ack  <= 1'b0;
      r_i_ack  <= 1'b0;
      r_mem_en <= 1'b0;

      case (r_state)
        S_IDLE: begin
          if (!bus.halt && w_any_req) begin
            r_state    <= S_ISSUE;
            r_busy     <= 1'b1;
            r_mem_en   <= 1'b1;
            r_gnt_data <= w_pick_data;
            if (w_pick_data) begin
              r_mem_we    <= bus.d_we;
              r_mem_addr  <= bus.d_addr;
              r_mem_wdata <= bus.d_wdata;
              if (w_contested) begin
                r_starve_cnt <= r_starve_cnt + 4'd1;
              end
            end else begin
              r_mem_we     <= 1'b0;
              r_mem_addr   <= bus.i_addr;
              r_mem_wdata  <= '0;
              r_starve_cnt <= '0;
            end
          end
        end

        S_ISSUE: begin
          if (r_mem_we) begin
            r_state <= S_DONE;
            r_d_ack <= r_gnt_data;
            r_i_ack <= !r_gnt_data;
          end else begin
            r_state   <= S_WAIT;
            r_lat_cnt <= 3'(RD_LAT - 1);
          end
        end

        S_WAIT: begin
          // The count reaching zero marks the cycle in which mem_rdata is valid.
          if (r_lat_cnt == 3'd0) begin
            r_state <= S_DONE;
            r_d_ack <= r_gnt_data;
            r_i_ack <= !r_gnt_data;
            if (r_gnt_data) begin
              r_d_rdata <= bus.mem_rdata;
            end else begin
              r_i_rdata <= bus.mem_rdata;
            end
          end else begin
            r_lat_cnt <= r_lat_cnt - 3'd1;
          end
        end

        S_DONE: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end

        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy      = r_busy;
  assign bus.gnt_data  = r_gnt_data;
  assign bus.d_ack     = r_d_ack;
  assign bus.d_rdata   = r_d_rdata;
  assign bus.i_ack     = r_i_ack;
  assign bus.i_rdata   = r_i_rdata;
  assign bus.mem_en    = r_mem_en;
  assign bus.mem_we    = r_mem_we;
  assign bus.mem_addr  = r_mem_addr;
  assign bus.mem_wdata = r_mem_wdata;

endmodule

// File: tb/tb_pipe_mem_arbiter.sv
// Directed bench for pipe_mem_arbiter: one instance at RD_LAT=2 and one at RD_LAT=1,
// each attached to a behavioural memory whose read data is poisoned outside its valid cycle.
module tb_pipe_mem_arbiter;

  localparam int DW = 32;
  localparam int AW = 10;
  localparam logic [DW-1:0] POISON = 32'hBAD0_BAD0;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  pipe_mem_arbiter_if #(.DW(DW), .AW(AW)) b2 ();
  pipe_mem_arbiter_if #(.DW(DW), .AW(AW)) b1 ();

  pipe_mem_arbiter #(.DW(DW), .AW(AW), .RD_LAT(2), .MAX_STARVE(3)) dut2 (
    .clk   (clk),
    .reset (reset),
    .bus   (b2.slave)
  );

  pipe_mem_arbiter #(.DW(DW), .AW(AW), .RD_LAT(1), .MAX_STARVE(3)) dut1 (
    .clk   (clk),
    .reset (reset),
    .bus   (b1.slave)
  );

  // Memory models with a preload port so contents are written from one process only.
  logic [DW-1:0] mem2 [1024];
  logic [DW-1:0] mem1 [1024];
  logic [DW-1:0] rp2  [2];
  logic [DW-1:0] rp1;
  logic          pl_we2, pl_we1;
  logic [AW-1:0] pl_addr;
  logic [DW-1:0] pl_data;

  always @(posedge clk) begin
    if (pl_we2) mem2[pl_addr] <= pl_data;
    else if (b2.mem_en && b2.mem_we) mem2[b2.mem_addr] <= b2.mem_wdata;
    rp2[0] <= (b2.mem_en && !b2.mem_we) ? mem2[b2.mem_addr] : POISON;
    rp2[1] <= rp2[0];
  end

  always @(posedge clk) begin
    if (pl_we1) mem1[pl_addr] <= pl_data;
    else if (b1.mem_en && b1.mem_we) mem1[b1.mem_addr] <= b1.mem_wdata;
    rp1 <= (b1.mem_en && !b1.mem_we) ? mem1[b1.mem_addr] : POISON;
  end

  assign b2.mem_rdata = rp2[1];
  assign b1.mem_rdata = rp1;

  int n_checks = 0;
  int n_errors = 0;
  int cyc      = 0;

  task automatic tick();
    @(negedge clk);
    cyc++;
  endtask

  task automatic preload(input logic sel2, input logic [AW-1:0] a, input logic [DW-1:0] d);
    pl_addr = a;
    pl_data = d;
    pl_we2  = sel2;
    pl_we1  = !sel2;
    tick();
    pl_we2  = 1'b0;
    pl_we1  = 1'b0;
  endtask

  task automatic test_reset();
    logic saw_busy;
    reset    = 1'b1;
    b2.i_req = 1'b1;
    b2.i_addr = 10'd5;
    saw_busy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      saw_busy |= b2.busy | b2.mem_en;
    end
    n_checks++;
    if ({b2.busy, b2.d_ack, b2.i_ack, b2.mem_en, b2.mem_we, b2.gnt_data,
         b2.mem_addr, b2.mem_wdata, b2.d_rdata, b2.i_rdata} !== '0) begin
      n_errors++;
      $display("FAIL reset_outputs_rl2: got busy=%b dack=%b iack=%b en=%b we=%b gnt=%b addr=%h wd=%h dr=%h ir=%h want all 0",
               b2.busy, b2.d_ack, b2.i_ack, b2.mem_en, b2.mem_we, b2.gnt_data,
               b2.mem_addr, b2.mem_wdata, b2.d_rdata, b2.i_rdata);
    end
    n_checks++;
    if ({b1.busy, b1.d_ack, b1.i_ack, b1.mem_en, b1.gnt_data, b1.d_rdata, b1.i_rdata} !== '0) begin
      n_errors++;
      $display("FAIL reset_outputs_rl1: got busy=%b dack=%b iack=%b en=%b gnt=%b dr=%h ir=%h want all 0",
               b1.busy, b1.d_ack, b1.i_ack, b1.mem_en, b1.gnt_data, b1.d_rdata, b1.i_rdata);
    end
    n_checks++;
    if (saw_busy !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_blocks_grant: got busy/mem_en seen=%b want 0", saw_busy);
    end
    n_checks++;
    if (dut2.r_starve_cnt !== 4'd0) begin
      n_errors++;
      $display("FAIL reset_starve_cnt: got %0d want 0", dut2.r_starve_cnt);
    end
    b2.i_req = 1'b0;
    reset    = 1'b0;
    tick();
    n_checks++;
    if (b2.busy !== 1'b0) begin
      n_errors++;
      $display("FAIL idle_no_req: got busy=%b want 0", b2.busy);
    end
  endtask

  task automatic test_fetch_read();
    logic saw_d;
    saw_d     = 1'b0;
    b2.i_addr = 10'd5;
    b2.i_req  = 1'b1;          // cycle T
    tick();                    // T+1
    saw_d |= b2.d_ack;
    n_checks++;
    if ({b2.mem_en, b2.mem_we, b2.mem_addr} !== {1'b1, 1'b0, 10'd5}) begin
      n_errors++;
      $display("FAIL fetch_issue: got en=%b we=%b addr=%h want en=1 we=0 addr=005",
               b2.mem_en, b2.mem_we, b2.mem_addr);
    end
    tick();                    // T+2
    saw_d |= b2.d_ack;
    n_checks++;
    if (b2.mem_en !== 1'b0) begin
      n_errors++;
      $display("FAIL fetch_strobe_width: got mem_en=%b at T+2 want 0", b2.mem_en);
    end
    tick();                    // T+3
    saw_d |= b2.d_ack;
    n_checks++;
    if (b2.i_ack !== 1'b0) begin
      n_errors++;
      $display("FAIL fetch_early_ack: got i_ack=%b at T+3 want 0", b2.i_ack);
    end
    tick();                    // T+4
    saw_d |= b2.d_ack;
    n_checks++;
    if ({b2.i_ack, b2.i_rdata} !== {1'b1, 32'h2001_000A}) begin
      n_errors++;
      $display("FAIL fetch_ack: got i_ack=%b i_rdata=%h want 1 2001000a", b2.i_ack, b2.i_rdata);
    end
    b2.i_req = 1'b0;
    tick();                    // T+5
    n_checks++;
    if ({b2.busy, b2.i_ack, saw_d, b2.gnt_data} !== 4'b0000) begin
      n_errors++;
      $display("FAIL fetch_after: got busy=%b i_ack=%b d_ack_seen=%b gnt_data=%b want 0000",
               b2.busy, b2.i_ack, saw_d, b2.gnt_data);
    end
  endtask

  task automatic test_store_load();
    int k;
    b2.d_we    = 1'b1;
    b2.d_addr  = 10'h3FF;
    b2.d_wdata = 32'hDEAD_BEEF;
    b2.d_req   = 1'b1;         // T
    tick();                    // T+1
    n_checks++;
    if ({b2.mem_en, b2.mem_we, b2.mem_addr, b2.mem_wdata} !== {1'b1, 1'b1, 10'h3FF, 32'hDEAD_BEEF}) begin
      n_errors++;
      $display("FAIL store_issue: got en=%b we=%b addr=%h wd=%h want 1 1 3ff deadbeef",
               b2.mem_en, b2.mem_we, b2.mem_addr, b2.mem_wdata);
    end
    tick();                    // T+2
    n_checks++;
    if ({b2.d_ack, b2.i_ack, b2.gnt_data, b2.d_rdata} !== {1'b1, 1'b0, 1'b1, 32'h0}) begin
      n_errors++;
      $display("FAIL store_ack: got d_ack=%b i_ack=%b gnt=%b d_rdata=%h want 1 0 1 00000000",
               b2.d_ack, b2.i_ack, b2.gnt_data, b2.d_rdata);
    end
    b2.d_we = 1'b0;            // new load presented with req held
    tick();                    // grant cycle T'
    n_checks++;
    if ({b2.d_ack, b2.busy} !== 2'b00) begin
      n_errors++;
      $display("FAIL store_idle_gap: got d_ack=%b busy=%b want 0 0", b2.d_ack, b2.busy);
    end
    k = 0;
    do begin
      tick();
      k++;
      if (k == 1) begin
        n_checks++;
        if ({b2.mem_en, b2.mem_we, b2.mem_addr} !== {1'b1, 1'b0, 10'h3FF}) begin
          n_errors++;
          $display("FAIL load_issue: got en=%b we=%b addr=%h want 1 0 3ff",
                   b2.mem_en, b2.mem_we, b2.mem_addr);
        end
      end
    end while (!b2.d_ack && k < 12);
    n_checks++;
    if (k !== 4) begin
      n_errors++;
      $display("FAIL load_latency: got ack at T+%0d want T+4", k);
    end
    n_checks++;
    if (b2.d_rdata !== 32'hDEAD_BEEF) begin
      n_errors++;
      $display("FAIL load_data: got %h want deadbeef", b2.d_rdata);
    end
    b2.d_req = 1'b0;
    tick();
  endtask

  task automatic test_starvation();
    string exp_order;
    byte   got [8];
    int    n;
    int    guard;
    logic  dual;
    exp_order = "DDDIDDDI";
    for (int i = 0; i < 8; i++) got[i] = ".";
    n     = 0;
    guard = 0;
    dual  = 1'b0;
    b2.d_we    = 1'b1;
    b2.d_addr  = 10'h100;
    b2.d_wdata = 32'hA5A5_A5A5;
    b2.i_addr  = 10'd5;
    b2.d_req   = 1'b1;
    b2.i_req   = 1'b1;
    while (n < 8 && guard < 200) begin
      tick();
      guard++;
      dual |= b2.d_ack & b2.i_ack;
      if (b2.d_ack || b2.i_ack) begin
        got[n] = b2.d_ack ? "D" : "I";
        if (b2.i_ack) begin
          n_checks++;
          if (dut2.r_starve_cnt !== 4'd0) begin
            n_errors++;
            $display("FAIL starve_clear_%0d: got starve_cnt=%0d want 0", n, dut2.r_starve_cnt);
          end
        end
        n++;
      end
    end
    b2.d_req = 1'b0;
    b2.i_req = 1'b0;
    tick();
    n_checks++;
    if (guard >= 200) begin
      n_errors++;
      $display("FAIL starve_timeout: got %0d acks in %0d cycles want 8", n, guard);
    end
    n_checks++;
    if (dual !== 1'b0) begin
      n_errors++;
      $display("FAIL starve_dual_ack: got both acks together=%b want 0", dual);
    end
    for (int i = 0; i < 8; i++) begin
      n_checks++;
      if (got[i] !== exp_order[i]) begin
        n_errors++;
        $display("FAIL grant_order_%0d: got %c want %c", i, got[i], exp_order[i]);
      end
    end
  endtask

  task automatic test_halt();
    logic idle_bad;
    idle_bad  = 1'b0;
    b2.i_addr = 10'd5;
    b2.i_req  = 1'b1;          // T
    tick();                    // T+1
    tick();                    // T+2, read in WAIT
    b2.halt    = 1'b1;
    b2.d_we    = 1'b1;
    b2.d_addr  = 10'h010;
    b2.d_wdata = 32'h1234_5678;
    b2.d_req   = 1'b1;
    tick();                    // T+3
    tick();                    // T+4
    n_checks++;
    if ({b2.i_ack, b2.i_rdata} !== {1'b1, 32'h2001_000A}) begin
      n_errors++;
      $display("FAIL halt_inflight_ack: got i_ack=%b i_rdata=%h want 1 2001000a", b2.i_ack, b2.i_rdata);
    end
    for (int i = 0; i < 5; i++) begin
      tick();
      idle_bad |= b2.busy | b2.mem_en | b2.i_ack | b2.d_ack;
    end
    n_checks++;
    if (idle_bad !== 1'b0) begin
      n_errors++;
      $display("FAIL halt_holds_idle: got activity=%b want 0", idle_bad);
    end
    b2.halt = 1'b0;            // cycle U
    tick();                    // U+1
    n_checks++;
    if ({b2.busy, b2.mem_en, b2.mem_we, b2.gnt_data, b2.mem_addr} !== {4'b1111, 10'h010}) begin
      n_errors++;
      $display("FAIL halt_release_grant: got busy=%b en=%b we=%b gnt=%b addr=%h want 1 1 1 1 010",
               b2.busy, b2.mem_en, b2.mem_we, b2.gnt_data, b2.mem_addr);
    end
    b2.i_req = 1'b0;
    tick();                    // U+2
    n_checks++;
    if (b2.d_ack !== 1'b1) begin
      n_errors++;
      $display("FAIL halt_release_ack: got d_ack=%b want 1", b2.d_ack);
    end
    b2.d_req = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid();
    logic early;
    early     = 1'b0;
    b2.i_addr = 10'd5;
    b2.i_req  = 1'b1;          // T
    tick();                    // T+1
    tick();                    // T+2, read in WAIT
    reset = 1'b1;
    tick();                    // T+3
    n_checks++;
    if ({b2.busy, b2.i_ack, b2.d_ack, b2.mem_en, b2.i_rdata} !== '0) begin
      n_errors++;
      $display("FAIL reset_mid_state: got busy=%b iack=%b dack=%b en=%b i_rdata=%h want all 0",
               b2.busy, b2.i_ack, b2.d_ack, b2.mem_en, b2.i_rdata);
    end
    n_checks++;
    if (dut2.r_starve_cnt !== 4'd0) begin
      n_errors++;
      $display("FAIL reset_mid_starve: got %0d want 0", dut2.r_starve_cnt);
    end
    reset = 1'b0;              // T+3 becomes the new grant cycle
    tick();                    // T+4
    n_checks++;
    if ({b2.mem_en, b2.mem_we, b2.mem_addr} !== {1'b1, 1'b0, 10'd5}) begin
      n_errors++;
      $display("FAIL reset_mid_regrant: got en=%b we=%b addr=%h want 1 0 005",
               b2.mem_en, b2.mem_we, b2.mem_addr);
    end
    for (int i = 0; i < 2; i++) begin
      tick();
      early |= b2.i_ack;
    end
    tick();                    // T+7
    n_checks++;
    if ({early, b2.i_ack, b2.i_rdata} !== {1'b0, 1'b1, 32'h2001_000A}) begin
      n_errors++;
      $display("FAIL reset_mid_ack: got early=%b i_ack=%b i_rdata=%h want 0 1 2001000a",
               early, b2.i_ack, b2.i_rdata);
    end
    b2.i_req = 1'b0;
    tick();
  endtask

  task automatic test_back_to_back();
    int   k;
    int   c1;
    logic hold_bad;
    hold_bad  = 1'b0;
    b1.d_we   = 1'b0;
    b1.d_addr = 10'd0;
    b1.d_req  = 1'b1;          // T
    k = 0;
    do begin
      tick();
      k++;
    end while (!b1.d_ack && k < 12);
    n_checks++;
    if ({k, b1.d_rdata} !== {32'd3, 32'h1111_0000}) begin
      n_errors++;
      $display("FAIL b2b_first: got ack at T+%0d d_rdata=%h want T+3 11110000", k, b1.d_rdata);
    end
    c1 = cyc;
    b1.d_addr = 10'd1;
    k = 0;
    do begin
      tick();
      k++;
      if (!b1.d_ack) hold_bad |= (b1.d_rdata !== 32'h1111_0000);
    end while (!b1.d_ack && k < 12);
    n_checks++;
    if (hold_bad !== 1'b0) begin
      n_errors++;
      $display("FAIL b2b_hold: got d_rdata changed before second ack want held 11110000");
    end
    n_checks++;
    if (cyc - c1 !== 4) begin
      n_errors++;
      $display("FAIL b2b_spacing: got %0d cycles between acks want 4", cyc - c1);
    end
    n_checks++;
    if (b1.d_rdata !== 32'h2222_0001) begin
      n_errors++;
      $display("FAIL b2b_second: got d_rdata=%h want 22220001", b1.d_rdata);
    end
    b1.d_req = 1'b0;
    tick();
  endtask

  initial begin
    reset   = 1'b1;
    pl_we2  = 1'b0;
    pl_we1  = 1'b0;
    pl_addr = '0;
    pl_data = '0;
    b2.halt = 1'b0; b2.d_req = 1'b0; b2.d_we = 1'b0; b2.d_addr = '0; b2.d_wdata = '0;
    b2.i_req = 1'b0; b2.i_addr = '0;
    b1.halt = 1'b0; b1.d_req = 1'b0; b1.d_we = 1'b0; b1.d_addr = '0; b1.d_wdata = '0;
    b1.i_req = 1'b0; b1.i_addr = '0;
    tick();
    preload(1'b1, 10'd5, 32'h2001_000A);
    preload(1'b0, 10'd0, 32'h1111_0000);
    preload(1'b0, 10'd1, 32'h2222_0001);

    test_reset();
    test_fetch_read();
    test_store_load();
    test_starvation();
    test_halt();
    test_reset_mid();
    test_back_to_back();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
